// File: rtl/hog_pkg.sv
// Shared types and default geometry for the HOG front-end scan sequencer.
package hog_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } hog_state_t;

    localparam int HOG_COLS   = 53;
    localparam int HOG_ROWS   = 128;
    localparam int HOG_CELL_H = 8;

endpackage

// File: rtl/hog_pos_counter.sv
// Raster row/column position counter; the row wraps to 0 after the last pixel of a frame.
module hog_pos_counter #(
    parameter int COLS  = 53,
    parameter int ROWS  = 128,
    parameter int ROW_W = 8,
    parameter int COL_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             row_end,
    output logic             frame_end
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    assign row_end   = enable && (col == COL_MAX);
    assign frame_end = row_end && (row == ROW_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (enable) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/hog_scan_ctrl.sv
// HOG front-end scan sequencer: raster pixel handshake with a histogram flush per cell band.
// Optional abort input is enabled by defining HOG_SCAN_CTRL_ABORT_EN.
//
//  state   | meaning
//  S_IDLE  | waiting for start; counters parked at 0/0
//  S_SCAN  | accepting pixels; counters advance on grad_en
//  S_FLUSH | input paused; hist_valid held until hist_ready
//  S_DONE  | one-cycle done pulse, then back to S_IDLE
module hog_scan_ctrl
    import hog_pkg::*;
#(
    parameter int COLS   = HOG_COLS,
    parameter int ROWS   = HOG_ROWS,
    parameter int CELL_H = HOG_CELL_H,
    parameter int ROW_W  = 8,
    parameter int COL_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
`ifdef HOG_SCAN_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             grad_en,
    output logic [ROW_W-1:0] cnt_row,
    output logic [COL_W-1:0] cnt_col,
    output logic             row_end,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic             hist_last
);

    localparam int BAND_W = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam logic [BAND_W-1:0] BAND_MAX = BAND_W'(CELL_H - 1);

    if (ROWS % CELL_H != 0) begin : g_bad_cell_h
        $error("hog_scan_ctrl: ROWS must be a multiple of CELL_H");
    end
    if ((2 ** ROW_W) < ROWS || (2 ** COL_W) < COLS) begin : g_bad_width
        $error("hog_scan_ctrl: ROW_W/COL_W too narrow for ROWS/COLS");
    end

    hog_state_t        state, state_nxt;
    logic              cnt_clear;
    logic              frame_end;
    logic              band_end;
    logic [BAND_W-1:0] band_row;
    logic              last_band;
    logic              abort_req;

`ifdef HOG_SCAN_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign pix_ready  = (state == S_SCAN);
    assign grad_en    = pix_valid && pix_ready;
    assign hist_valid = (state == S_FLUSH);
    assign hist_last  = hist_valid && last_band;
    assign band_end   = row_end && (band_row == BAND_MAX);

    hog_pos_counter #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .enable    (grad_en),
        .clear     (cnt_clear),
        .row       (cnt_row),
        .col       (cnt_col),
        .row_end   (row_end),
        .frame_end (frame_end)
    );

    // The last-band decision is latched at band end because cnt_row has already wrapped by FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            band_row  <= '0;
            last_band <= 1'b0;
        end else if (cnt_clear) begin
            band_row  <= '0;
            last_band <= 1'b0;
        end else if (row_end) begin
            band_row  <= (band_row == BAND_MAX) ? '0 : band_row + BAND_W'(1);
            if (band_end) begin
                last_band <= frame_end;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clear = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SCAN;
                    cnt_clear = 1'b1;
                end
            end
            S_SCAN: begin
                if (band_end) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (hist_ready) begin
                    state_nxt = last_band ? S_DONE : S_SCAN;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort_req && (state == S_SCAN || state == S_FLUSH)) begin
            state_nxt = S_IDLE;
            cnt_clear = 1'b1;
        end
    end

endmodule
